// File: rtl/formula_pkg.sv
// ---------------------------------------------------------------------------
// formula_pkg
// Shared definitions for the formula pipes and their output-side companions.
//   arg_width / res_width : data widths of pipe arguments and results
//   clog2_plus1()         : width of a counter that must hold 0..value inclusive
//   cnt_op_t              : up/down/hold action for occupancy-style counters
// ---------------------------------------------------------------------------
package formula_pkg;

   localparam int arg_width = 32;
   localparam int res_width = 32;

   // A counter ranging over 0..value (value a power of two) needs one bit more
   // than the index width, so "completely full" is distinguishable from zero.
   function automatic int clog2_plus1(input int value);
      return $clog2(value) + 1;
   endfunction

   typedef enum logic [1:0] {
      cnt_hold = 2'd0,
      cnt_inc  = 2'd1,
      cnt_dec  = 2'd2
   } cnt_op_t;

endpackage

// File: rtl/flip_flop_fifo_no_bypass.sv
// ---------------------------------------------------------------------------
// flip_flop_fifo_no_bypass
// Register-based FIFO without fall-through: a word pushed into an empty FIFO
// appears at the head one cycle later.
//   clk, rst    : clock, synchronous active-high reset (clears pointers)
//   push        : write push_data this cycle (dropped if full and no pop)
//   push_data   : write data
//   pop         : consume the head this cycle (ignored when empty)
//   pop_data    : head data, don't-care while empty
//   empty, full : status from the registered pointers
//   occupancy   : stored entries, 0..depth
// ---------------------------------------------------------------------------
module flip_flop_fifo_no_bypass
   import formula_pkg::*;
#(
   parameter  int width     = res_width,
   parameter  int depth     = 16,
   localparam int ptr_width = clog2_plus1(depth)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 push,
   input  logic [width-1:0]     push_data,
   input  logic                 pop,
   output logic [width-1:0]     pop_data,
   output logic                 empty,
   output logic                 full,
   output logic [ptr_width-1:0] occupancy
);

   localparam int idx_width = ptr_width - 1;

   // Pointers carry one wrap bit above the index so full and empty differ.
   logic [ptr_width-1:0] wr_ptr;
   logic [ptr_width-1:0] rd_ptr;
   logic [width-1:0]     mem [depth];

   logic push_ok;
   logic pop_ok;

   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[idx_width-1:0] == rd_ptr[idx_width-1:0]) &&
                  (wr_ptr[idx_width] != rd_ptr[idx_width]);

   // When full, a push is only taken if the head leaves in the same cycle; the
   // write lands in the slot being vacated, whose old value is read this cycle.
   assign push_ok = push && (!full || pop);
   assign pop_ok  = pop && !empty;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + ptr_width'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + ptr_width'(1);
      end
   end

   // NOTE: storage is deliberately not reset; empty/out_vld derive from the
   // pointers, so stale words can never be presented and the array stays plain
   // flops/RAM without a reset network.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[idx_width-1:0]] <= push_data;
   end

   assign pop_data  = mem[rd_ptr[idx_width-1:0]];
   assign occupancy = wr_ptr - rd_ptr;

endmodule

// File: rtl/formula_res_credit_fifo.sv
// ---------------------------------------------------------------------------
// formula_res_credit_fifo
// Output-side companion for the formula pipes, which have no backpressure.
// Arguments are only issued while a result slot is reserved for them, so a
// result can always be buffered even when the consumer stalls.
//   clk, rst     : clock, synchronous active-high reset (also resets the pipe)
//   up_arg_vld   : argument source has an argument
//   up_arg_rdy   : a credit is available; argument may be issued
//   pipe_arg_vld : arg_vld towards the pipe (= up_arg_vld & up_arg_rdy)
//   pipe_res_vld : result valid from the pipe
//   pipe_res     : result data from the pipe
//   out_vld      : FIFO head valid
//   out_rdy      : consumer accepts the head
//   out_data     : FIFO head data
//   occupancy    : entries currently stored
//   err          : sticky protocol/overflow error, cleared only by rst
// ---------------------------------------------------------------------------
module formula_res_credit_fifo
   import formula_pkg::*;
#(
   parameter  int width     = res_width,
   parameter  int depth     = 16,
   localparam int cnt_width = clog2_plus1(depth)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 up_arg_vld,
   output logic                 up_arg_rdy,
   output logic                 pipe_arg_vld,
   input  logic                 pipe_res_vld,
   input  logic [width-1:0]     pipe_res,
   output logic                 out_vld,
   input  logic                 out_rdy,
   output logic [width-1:0]     out_data,
   output logic [cnt_width-1:0] occupancy,
   output logic                 err
);

   // Arguments issued but whose results have not yet been popped (0..depth).
   logic [cnt_width-1:0] reserved;
   logic [cnt_width-1:0] in_flight;
   cnt_op_t              reserved_op;

   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic unexpected_res;
   logic overflow;

   // Credit gate: registered state only. A pop this cycle frees a credit
   // from the next cycle on, keeping the path from out_rdy to the source short.
   assign up_arg_rdy   = (reserved != cnt_width'(depth)) && !rst;
   assign pipe_arg_vld = up_arg_vld && up_arg_rdy;

   // The FIFO resets synchronously, so its contents are masked during rst.
   assign out_vld = !fifo_empty && !rst;
   assign pop     = out_vld && out_rdy;

   flip_flop_fifo_no_bypass #(
      .width (width),
      .depth (depth)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (pipe_res_vld),
      .push_data (pipe_res),
      .pop       (pop),
      .pop_data  (out_data),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .occupancy (occupancy)
   );

   // NOTE: every always_comb output gets a default before any condition, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      reserved_op = cnt_hold;
      if (pipe_arg_vld && !pop) begin
         reserved_op = cnt_inc;
      end else if (!pipe_arg_vld && pop) begin
         reserved_op = cnt_dec;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         reserved <= '0;
      end else begin
         case (reserved_op)
            cnt_inc: reserved <= reserved + cnt_width'(1);
            cnt_dec: reserved <= reserved - cnt_width'(1);
            default: reserved <= reserved;
         endcase
      end
   end

   // Results still inside the pipe: reserved slots not yet filled.
   assign in_flight = reserved - occupancy;

   // A result with nothing outstanding means the pipe was driven without a
   // credit; a result into a full FIFO without a pop is dropped by the FIFO.
   assign unexpected_res = pipe_res_vld && (in_flight == '0);
   assign overflow       = pipe_res_vld && fifo_full && !pop;

   always_ff @(posedge clk) begin
      if (rst) begin
         err <= 1'b0;
      end else if (unexpected_res || overflow) begin
         err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_formula_res_credit_fifo.sv
// ---------------------------------------------------------------------------
// tb_formula_res_credit_fifo
// Two instances (depth 4 and depth 16), each fed by a small 2-stage pipe model
// computing formula_1_fn. Expected results are queued when an argument is
// issued and compared when the consumer pops the FIFO head.
// ---------------------------------------------------------------------------
module tb_formula_res_credit_fifo;

   localparam int lat = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        up_arg_vld;
   logic        out_rdy;
   logic        force_vld;
   logic [31:0] force_data;
   logic        sel;
   logic [31:0] a, b, c;

   // depth 4 instance
   logic        av4, rdy4, pav4, prv4, ov4, err4;
   logic [31:0] pr4, od4;
   logic [2:0]  occ4;
   logic [lat-1:0] v4;
   logic [31:0]    d4 [lat];

   // depth 16 instance
   logic        av16, rdy16, pav16, prv16, ov16, err16;
   logic [31:0] pr16, od16;
   logic [4:0]  occ16;
   logic [lat-1:0] v16;
   logic [31:0]    d16 [lat];

   function automatic logic [31:0] formula_1_fn(input logic [31:0] x, y, z);
      return x * x + y * 32'd3 + z;
   endfunction

   assign av4  = up_arg_vld & ~sel;
   assign av16 = up_arg_vld & sel;
   assign prv4 = v4[lat-1] | force_vld;
   assign pr4  = force_vld ? force_data : d4[lat-1];
   assign prv16 = v16[lat-1];
   assign pr16  = d16[lat-1];

   // Pipe models: fixed latency, no backpressure, reset with the same rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         v4  <= '0;
         v16 <= '0;
      end else begin
         v4  <= {v4[lat-2:0], pav4};
         v16 <= {v16[lat-2:0], pav16};
      end
      d4[0]  <= formula_1_fn(a, b, c);
      d16[0] <= formula_1_fn(a, b, c);
      for (int i = 1; i < lat; i++) begin
         d4[i]  <= d4[i-1];
         d16[i] <= d16[i-1];
      end
   end

   formula_res_credit_fifo #(.width(32), .depth(4)) dut4 (
      .clk (clk), .rst (rst),
      .up_arg_vld (av4), .up_arg_rdy (rdy4), .pipe_arg_vld (pav4),
      .pipe_res_vld (prv4), .pipe_res (pr4),
      .out_vld (ov4), .out_rdy (out_rdy), .out_data (od4),
      .occupancy (occ4), .err (err4)
   );

   formula_res_credit_fifo #(.width(32), .depth(16)) dut16 (
      .clk (clk), .rst (rst),
      .up_arg_vld (av16), .up_arg_rdy (rdy16), .pipe_arg_vld (pav16),
      .pipe_res_vld (prv16), .pipe_res (pr16),
      .out_vld (ov16), .out_rdy (out_rdy), .out_data (od16),
      .occupancy (occ16), .err (err16)
   );

   // Outputs of the instance under test
   logic        s_pav, s_rdy, s_ovld, s_err;
   logic [31:0] s_odata, s_occ;
   always_comb begin
      s_pav   = sel ? pav16 : pav4;
      s_rdy   = sel ? rdy16 : rdy4;
      s_ovld  = sel ? ov16  : ov4;
      s_err   = sel ? err16 : err4;
      s_odata = sel ? od16  : od4;
      s_occ   = sel ? {27'd0, occ16} : {29'd0, occ4};
   end

   int          total = 0;
   int          bad   = 0;
   int          n_issued = 0;
   int          n_popped = 0;
   bit          rnd = 1'b0;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock cycle: sample handshakes just after the negedge drive, push the
   // expected result on issue, compare on pop, return at the next negedge.
   task automatic tick();
      logic        acc, pp;
      logic [31:0] e;
      #1;
      acc = s_pav;
      pp  = s_ovld & out_rdy;
      if (acc) begin
         exp_q.push_back(formula_1_fn(a, b, c));
         n_issued++;
      end
      if (pp) begin
         check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("result", s_odata, e);
         end
         n_popped++;
      end
      @(posedge clk);
      @(negedge clk);
      if (acc) begin
         if (rnd) begin
            a = $urandom;
            b = $urandom;
            c = $urandom;
         end else begin
            a = a + 32'd1;
            b = a;
            c = a;
         end
      end
   endtask

   task automatic drain(input int budget);
      out_rdy    = 1'b1;
      up_arg_vld = 1'b0;
      for (int i = 0; i < budget && exp_q.size() != 0; i++) tick();
      check("drained", 32'(exp_q.size()), 32'd0);
   endtask

   initial begin
      int base_i, base_p;
      logic [31:0] max_occ;

      rst = 1'b1; up_arg_vld = 1'b0; out_rdy = 1'b0;
      force_vld = 1'b0; force_data = '0; sel = 1'b0;
      a = '0; b = '0; c = '0;

      // Reset state
      @(negedge clk);
      #1;
      check("rst_out_vld", 32'(s_ovld), 32'd0);
      check("rst_arg_rdy", 32'(s_rdy), 32'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_arg_rdy", 32'(s_rdy), 32'd1);
      check("post_rst_occ", s_occ, 32'd0);
      check("post_rst_err", 32'(s_err), 32'd0);
      check("post_rst_out_vld", 32'(s_ovld), 32'd0);

      // Back-to-back args with the consumer always ready
      out_rdy = 1'b1;
      up_arg_vld = 1'b1;
      base_p = n_popped;
      for (int i = 0; i < 20; i++) begin
         #1;
         check("t1_arg_issue", 32'(s_pav), 32'd1);
         tick();
      end
      drain(40);
      check("t1_results", 32'(n_popped - base_p), 32'd20);
      check("t1_err", 32'(s_err), 32'd0);

      // Stalled consumer: exactly depth credits are issued
      out_rdy = 1'b0;
      a = '0; b = '0; c = '0;
      up_arg_vld = 1'b1;
      base_i = n_issued;
      repeat (12) tick();
      check("t2_issued", 32'(n_issued - base_i), 32'd4);
      check("t2_arg_rdy", 32'(s_rdy), 32'd0);
      check("t2_occ", s_occ, 32'd4);
      check("t2_head", s_odata, formula_1_fn(32'd0, 32'd0, 32'd0));

      // One pop frees exactly one credit, from the next cycle on
      out_rdy = 1'b1;
      tick();
      out_rdy = 1'b0;
      #1;
      check("t3_occ", s_occ, 32'd3);
      check("t3_arg_rdy", 32'(s_rdy), 32'd1);
      base_i = n_issued;
      repeat (8) tick();
      check("t3_issued", 32'(n_issued - base_i), 32'd1);
      check("t3_occ_full", s_occ, 32'd4);
      check("t3_arg_rdy_low", 32'(s_rdy), 32'd0);
      check("t3_err", 32'(s_err), 32'd0);
      drain(20);
      check("t3_occ_drained", s_occ, 32'd0);

      // Result with nothing reserved sets the sticky error
      out_rdy = 1'b0;
      force_data = 32'h1234;
      force_vld = 1'b1;
      tick();
      force_vld = 1'b0;
      #1;
      check("t4_err_set", 32'(s_err), 32'd1);
      check("t4_occ", s_occ, 32'd1);
      repeat (3) tick();
      check("t4_err_sticky", 32'(s_err), 32'd1);

      // Reset mid-stream with a full FIFO
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      a = '0; b = '0; c = '0;
      #1;
      check("t5_err_cleared", 32'(s_err), 32'd0);
      up_arg_vld = 1'b1;
      repeat (8) tick();
      check("t5_filled", s_occ, 32'd4);
      rst = 1'b1;
      #1;
      check("t5_rst_out_vld", 32'(s_ovld), 32'd0);
      check("t5_rst_arg_rdy", 32'(s_rdy), 32'd0);
      tick();
      rst = 1'b0;
      exp_q.delete();
      up_arg_vld = 1'b0;
      #1;
      check("t5_out_vld", 32'(s_ovld), 32'd0);
      check("t5_occ", s_occ, 32'd0);
      check("t5_arg_rdy", 32'(s_rdy), 32'd1);
      check("t5_err", 32'(s_err), 32'd0);
      out_rdy = 1'b1;
      for (int i = 0; i < 6; i++) begin
         #1;
         check("t5_no_stale", 32'(s_ovld), 32'd0);
         tick();
      end

      // Random backpressure on the depth-16 instance
      sel = 1'b1;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      exp_q.delete();
      rnd = 1'b1;
      a = $urandom; b = $urandom; c = $urandom;
      base_i = n_issued;
      base_p = n_popped;
      max_occ = '0;
      for (int cyc = 0; cyc < 3000; cyc++) begin
         if ((n_issued - base_i) >= 200 && exp_q.size() == 0) break;
         up_arg_vld = ((n_issued - base_i) < 200);
         out_rdy    = 1'($urandom_range(0, 1));
         #1;
         if (s_occ > max_occ) max_occ = s_occ;
         tick();
      end
      check("t6_issued", 32'(n_issued - base_i), 32'd200);
      check("t6_delivered", 32'(n_popped - base_p), 32'd200);
      check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
      check("t6_err", 32'(s_err), 32'd0);
      check("t6_occ_bound", 32'(max_occ <= 32'd16), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
